// File: rtl/round_scorer_if.sv
// Game-control bundle between the checker/prompt side (master) and round_scorer (slave).
`timescale 1ns/1ps
interface round_scorer_if;
  logic        start;
  logic        verdict_tgl;
  logic        verdict_ok;
  logic        prompt_req;
  logic        round_active;
  logic [5:0]  seconds_left;
  logic [11:0] score_bcd;
  logic [7:0]  round_num;
  logic [2:0]  lives_left;
  logic        game_over;

  modport master (
    output start, verdict_tgl, verdict_ok,
    input  prompt_req, round_active, seconds_left, score_bcd, round_num, lives_left, game_over
  );

  modport slave (
    input  start, verdict_tgl, verdict_ok,
    output prompt_req, round_active, seconds_left, score_bcd, round_num, lives_left, game_over
  );
endinterface

// File: rtl/round_scorer.sv
// Switch-game sequencer: round countdown, gap timer, lives and saturating BCD score.
// Define SCORER_STREAK_BONUS_EN to enable the streak-based doubling of points per pass.
`timescale 1ns/1ps
module round_scorer #(
  parameter int CLK_HZ     = 50000000,
  parameter int ROUND_SECS = 15,
  parameter int GAP_SECS   = 5,
  parameter int LIVES      = 3
) (
  input  logic          clk,
  input  logic          reset_btn,
  round_scorer_if.slave bus
);
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PROMPT = 3'd1;
  localparam logic [2:0] S_ACTIVE = 3'd2;
  localparam logic [2:0] S_ADD    = 3'd3;
  localparam logic [2:0] S_MISS   = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;
  localparam logic [2:0] S_OVER   = 3'd6;

  logic [2:0]    r_state;
  logic          r_prev_tgl;
  logic [PW-1:0] r_presc;
  logic          r_prompt_req;
  logic [5:0]    r_secs;
  logic [11:0]   r_score;
  logic [7:0]    r_round;
  logic [2:0]    r_lives;
  logic          r_game_over;
  logic [7:0]    r_streak;
  logic [4:0]    r_pts_left;

  logic          w_event;
  logic          w_tick;
  logic          w_timeout;
  logic [4:0]    w_pts;
  logic [11:0]   w_score_inc;
  logic [2:0]    w_lives_dec;

  assign w_event     = (bus.verdict_tgl != r_prev_tgl);
  assign w_tick      = (r_presc == PRESC_LAST);
  assign w_timeout   = w_tick && (r_secs == 6'd1);
  assign w_lives_dec = r_lives - 3'd1;

  always_comb begin
`ifdef SCORER_STREAK_BONUS_EN
    if (r_streak >= 8'd15)      w_pts = 5'd16;
    else if (r_streak >= 8'd10) w_pts = 5'd8;
    else if (r_streak >= 8'd5)  w_pts = 5'd4;
    else                        w_pts = 5'd2;
`else
    w_pts = 5'd2;
`endif
  end

  // BCD +1 with 999 as a hard ceiling.
  always_comb begin
    w_score_inc = r_score;
    if (r_score != 12'h999) begin
      if (r_score[3:0] != 4'd9) begin
        w_score_inc[3:0] = r_score[3:0] + 4'd1;
      end else begin
        w_score_inc[3:0] = 4'd0;
        if (r_score[7:4] != 4'd9) begin
          w_score_inc[7:4] = r_score[7:4] + 4'd1;
        end else begin
          w_score_inc[7:4]  = 4'd0;
          w_score_inc[11:8] = r_score[11:8] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset_btn) begin
    if (reset_btn) begin
      r_state      <= S_IDLE;
      r_prev_tgl   <= 1'b0;
      r_presc      <= '0;
      r_prompt_req <= 1'b0;
      r_secs       <= 6'd0;
      r_score      <= 12'h000;
      r_round      <= 8'd0;
      r_lives      <= 3'(LIVES);
      r_game_over  <= 1'b0;
      r_streak     <= 8'd0;
      r_pts_left   <= 5'd0;
    end else begin
      r_prev_tgl <= bus.verdict_tgl;
      r_presc    <= w_tick ? '0 : r_presc + PRESC_ONE;
      case (r_state)
        S_IDLE, S_OVER: begin
          if (bus.start) begin
            r_score     <= 12'h000;
            r_round     <= 8'd0;
            r_streak    <= 8'd0;
            r_lives     <= 3'(LIVES);
            r_game_over <= 1'b0;
            r_state     <= S_PROMPT;
          end
        end
        S_PROMPT: begin
          r_prompt_req <= ~r_prompt_req;
          r_secs       <= 6'(ROUND_SECS);
          if (r_round != 8'hFF) r_round <= r_round + 8'd1;
          r_presc      <= '0;
          r_state      <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (w_tick) r_secs <= r_secs - 6'd1;
          // A verdict arriving on the timeout cycle takes priority over the timeout.
          if (w_event && bus.verdict_ok) begin
            r_pts_left <= w_pts;
            r_state    <= S_ADD;
          end else if (w_event || w_timeout) begin
            r_state <= S_MISS;
          end
        end
        S_ADD: begin
          r_score    <= w_score_inc;
          r_pts_left <= r_pts_left - 5'd1;
          if (r_pts_left == 5'd1) begin
            if (r_streak != 8'hFF) r_streak <= r_streak + 8'd1;
            r_secs  <= 6'(GAP_SECS);
            r_presc <= '0;
            r_state <= S_GAP;
          end
        end
        S_MISS: begin
          r_streak <= 8'd0;
          r_lives  <= w_lives_dec;
          if (w_lives_dec == 3'd0) begin
            r_game_over <= 1'b1;
            r_state     <= S_OVER;
          end else begin
            r_secs  <= 6'(GAP_SECS);
            r_presc <= '0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (w_tick) begin
            r_secs <= r_secs - 6'd1;
            if (r_secs == 6'd1) r_state <= S_PROMPT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.prompt_req   = r_prompt_req;
  assign bus.round_active = (r_state == S_ACTIVE);
  assign bus.seconds_left = r_secs;
  assign bus.score_bcd    = r_score;
  assign bus.round_num    = r_round;
  assign bus.lives_left   = r_lives;
  assign bus.game_over    = r_game_over;
endmodule

// File: doc/round_scorer.md
# round_scorer

Game-sequencing block for the switch game. It receives verdict events from the switch-arrangement checker and requests new prompts from the LED prompt generator. It runs the per-round countdown and the inter-round gap, tracks lives, and keeps a BCD score with a streak bonus. It sits between the checker (upstream verdicts) and the prompt generator and HEX displays (downstream).

## Interface
- CLK_HZ, 50000000: input clock frequency; the 1 Hz tick prescaler counts CLK_HZ cycles.
- ROUND_SECS, 15: round length in seconds (1..63).
- GAP_SECS, 5: gap between rounds in seconds (1..63).
- LIVES, 3: misses allowed before game over (1..7).
- clk  input  1  system clock.
- reset_btn  input  1  asynchronous, active-high reset.
- start  input  1  level-sampled; a high cycle in IDLE or OVER starts a game.
- verdict_tgl  input  1  toggle handshake from the checker; each change of level is one verdict event.
- verdict_ok  input  1  pass/fail; sampled in the same cycle the toggle change is detected.
- prompt_req  output  1  toggle to the prompt generator; each change requests one new prompt.
- round_active  output  1  high while in ACTIVE.
- seconds_left  output  6  countdown value for the HEX timer digits.
- score_bcd  output  12  three BCD digits, 000..999.
- round_num  output  8  rounds started, saturating at 255.
- lives_left  output  3  remaining lives.
- game_over  output  1  high in OVER.

## Operation
- Event detect: a prev_tgl register is updated every cycle. An event is verdict_tgl != prev_tgl. prev_tgl resets to 0.
- 1 Hz tick: the prescaler pulses tick for one cycle every CLK_HZ cycles. It clears on every entry to ACTIVE and to GAP, so the first second is always full length.
- FSM states: IDLE, PROMPT, ACTIVE, ADD, MISS, GAP, OVER.
  - IDLE/OVER, start=1: clear score, round_num, streak; load lives_left=LIVES; clear game_over; go to PROMPT.
  - PROMPT (1 cycle): toggle prompt_req, load seconds_left=ROUND_SECS, increment round_num with saturation, go to ACTIVE.
  - ACTIVE: on tick, decrement seconds_left.
    - Event with ok=1: go to ADD with pts_left = points for this round.
    - Event with ok=0: go to MISS.
    - Tick that takes seconds_left from 1 to 0: timeout, go to MISS.
    - Event and timeout in the same cycle: the event wins.
    - Events outside ACTIVE are consumed and ignored.
  - ADD: each cycle, BCD-increment score_bcd by 1 and decrement pts_left. Score saturates at 999; further increments hold. When pts_left reaches 0, increment streak (saturating at 255) and go to GAP.
  - MISS (1 cycle): clear streak and decrement lives_left. If the result is 0, go to OVER (game_over=1). Otherwise go to GAP.
  - GAP: load seconds_left=GAP_SECS on entry and decrement on each tick. Reaching 0 goes to PROMPT.
- Points: pts = 2 << min(streak/5, 3), evaluated on entry to ADD using the streak before increment. Passes 1–5 earn 2, 6–10 earn 4, 11–15 earn 8, and later passes earn 16.
- BCD increment: a digit at 9 becomes 0 with carry into the next digit. 999 is the ceiling.
- A start press during an active game is ignored.

## Timing
- Reset values: prompt_req 0, round_active 0, seconds_left 0, score_bcd 000, round_num 0, lives_left LIVES, game_over 0, state IDLE, streak 0, prescaler 0.
- Reset mid-game returns to IDLE immediately and asynchronously. prompt_req returns to 0; this may look like one extra toggle downstream, which is accepted.
- start=1 in IDLE → PROMPT on the next edge → prompt_req toggles and round_active rises one edge later (2 cycles after start).
- Verdict latency: detected event → next state entered on the following edge. An ADD of k points takes k cycles, then GAP.
- seconds_left changes only on tick cycles or on PROMPT/GAP loads.
- A timeout occurs exactly ROUND_SECS×CLK_HZ cycles after ACTIVE entry.

## Configuration
- SCORER_STREAK_BONUS_EN defined: the streak doubling schedule above applies.
- SCORER_STREAK_BONUS_EN undefined: pts is fixed at 2. The streak register is still maintained but does not affect scoring.

## Test plan
Benches use CLK_HZ=10, ROUND_SECS=3, GAP_SECS=2, LIVES=3.
- Reset, then start=1 for 1 cycle → prompt_req 0→1 at cycle 2; round_active=1; seconds_left=3; round_num=1.
- Toggle verdict_tgl with ok=1 at 5 cycles into ACTIVE → 2 ADD cycles; score_bcd=002; GAP with seconds_left=2; after 20 cycles PROMPT, and prompt_req toggles again.
- No verdict → seconds_left goes 3,2,1,0 at 10-cycle intervals; MISS; lives_left=2; score unchanged; streak cleared.
- Six consecutive passes → score 2×5+4=014 with macro defined, 012 without.
- Preload score 998 with streak ≥15, then pass → score saturates at 999 (16 ADD cycles, held).
- Verdict ok=0 and timeout tick in the same cycle → a single MISS (lives 3→2, not 1). Three misses → game_over=1 and lives_left=0. A toggle while in OVER is ignored. start=1 then restarts with score 000.
